// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the multi-lane bit-serial word adder.
package serial_adder_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int unsigned OVF_UNSIGNED = 0;
    localparam int unsigned OVF_SIGNED   = 1;
    localparam int unsigned OVF_CNT_W    = 8;

    localparam logic [OVF_CNT_W-1:0] OVF_CNT_MAX = '1;

    // Carry out of a full adder.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/serial_adder_lane.sv
// One lane of the serial adder: running carry, registered sum bit and word overflow.
// Optional saturating overflow counter under SERIAL_WORD_ADDER_OVF_CNT_EN.
module serial_adder_lane
    import serial_adder_pkg::*;
#(
    parameter int unsigned SIGNED_MODE = OVF_UNSIGNED
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic accept,
    input  logic last,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic ovf
`ifdef SERIAL_WORD_ADDER_OVF_CNT_EN
    ,
    output logic [OVF_CNT_W-1:0] ovf_count
`endif
);

    logic carry_q;
    logic sum_c;
    logic cout_c;
    logic ovf_c;

    // carry_q is the carry into the current bit, so at the MSB it is the signed-rule carry-in.
    always_comb begin
        sum_c  = a ^ b ^ carry_q;
        cout_c = maj3(a, b, carry_q);
        if (SIGNED_MODE == OVF_SIGNED) begin
            ovf_c = carry_q ^ cout_c;
        end else begin
            ovf_c = cout_c;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            carry_q <= 1'b0;
            sum     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            sum <= accept & sum_c;
            ovf <= accept & last & ovf_c;
            if (clear || (accept && last)) begin
                carry_q <= 1'b0;
            end else if (accept) begin
                carry_q <= cout_c;
            end
        end
    end

`ifdef SERIAL_WORD_ADDER_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] cnt_q;

    // Counts in step with the overflw register so the value is current once word_done is seen.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (accept && last && ovf_c && (cnt_q != OVF_CNT_MAX)) begin
            cnt_q <= cnt_q + OVF_CNT_W'(1);
        end
    end

    assign ovf_count = cnt_q;
`endif

endmodule

// File: rtl/serial_word_adder.sv
// Multi-lane LSB-first serial adder with word framing, clear and per-word overflow.
// Define SERIAL_WORD_ADDER_OVF_CNT_EN to add the per-lane saturating ovf_count output.
module serial_word_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WORD_LEN    = 8,
    parameter int unsigned LANES       = 1,
    parameter int unsigned SIGNED_MODE = OVF_UNSIGNED
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             clear,
    input  logic [LANES-1:0] line1,
    input  logic [LANES-1:0] line2,
    output logic [LANES-1:0] outp,
    output logic             out_valid,
    output logic [LANES-1:0] overflw,
    output logic             word_done
`ifdef SERIAL_WORD_ADDER_OVF_CNT_EN
    ,
    output logic [LANES*OVF_CNT_W-1:0] ovf_count
`endif
);

    localparam int unsigned CNT_W = $clog2(WORD_LEN);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_LEN - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             accept_c;
    logic             last_c;

    assign accept_c = in_valid && !clear;
    assign last_c   = (state_q == ST_RUN) && (count_q == LAST_BIT);

    // Word framing: bit 0 is taken in IDLE, the final bit returns to IDLE.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (clear) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else if (in_valid) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
                    count_d = CNT_W'(1);
                end
                ST_RUN: begin
                    if (count_q == LAST_BIT) begin
                        state_d = ST_IDLE;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            out_valid <= 1'b0;
            word_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            out_valid <= accept_c;
            word_done <= accept_c && last_c;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        serial_adder_lane #(
            .SIGNED_MODE (SIGNED_MODE)
        ) u_lane (
            .clock     (clock),
            .reset_n   (reset_n),
            .clear     (clear),
            .accept    (accept_c),
            .last      (last_c),
            .a         (line1[i]),
            .b         (line2[i]),
            .sum       (outp[i]),
            .ovf       (overflw[i])
`ifdef SERIAL_WORD_ADDER_OVF_CNT_EN
            ,
            .ovf_count (ovf_count[i*OVF_CNT_W +: OVF_CNT_W])
`endif
        );
    end

endmodule
